// File: rtl/router_pkg.sv
// Shared types and constants for the 1xN router control path.
// Holds the state encoding, default sizing and the address-width helper.
package router_pkg;

    localparam int DEF_NUM_CH       = 3;
    localparam int DEF_WAIT_TIMEOUT = 64;

    typedef enum logic [3:0] {
        DECODE_ADDR        = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        LOAD_PARITY        = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        WAIT_TILL_EMPTY    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP               = 4'd8
    } state_t;

    // Header address width for a given channel count, never narrower than one bit.
    function automatic int addr_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Loadable down-counter with synchronous clear and a terminal-count flag.
// Counts down to zero and holds there; tc is high whenever the count is zero.
module router_wait_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/router_fsm_nch.sv
// Control FSM for a 1xN packet router: header decode, payload load, full stall,
// parity load/check, plus a drop path for bad addresses and a bounded wait on busy FIFOs.
//
// state              | meaning
// DECODE_ADDR        | idle, waiting for a header byte
// LOAD_FIRST_DATA    | header accepted, first byte loading
// LOAD_DATA          | payload bytes written to the selected FIFO
// LOAD_PARITY        | parity byte written
// FIFO_FULL_STATE    | stalled on a full destination FIFO
// LOAD_AFTER_FULL    | writing the byte held during the stall
// WAIT_TILL_EMPTY    | destination busy, bounded wait for it to drain
// CHECK_PARITY_ERROR | parity compare cycle
// DROP               | discarding a packet until pkt_valid falls
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int ADDR_W       = addr_w(NUM_CH),
    parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic [ADDR_W-1:0] addr_sel,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              drop_pkt,
    output logic              timeout
);

    localparam int                CNT_W      = $clog2(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0]  WAIT_LOAD  = CNT_W'(WAIT_TIMEOUT - 1);
    localparam int                SEL_W      = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   NUM_CH_CMP = (ADDR_W + 1)'(NUM_CH);

    state_t           state;
    state_t           next_state;
    logic [SEL_W-1:0] empty_pad;
    logic [SEL_W-1:0] srst_pad;
    logic             addr_ok;
    logic             hdr_empty;
    logic             sel_empty;
    logic             sel_srst;
    logic             wait_load;
    logic             wait_clear;
    logic             wait_dec;
    logic             wait_tc;

    // Pad per-channel flags to a power of two so any address value indexes safely.
    always_comb begin
        empty_pad               = '0;
        srst_pad                = '0;
        empty_pad[NUM_CH-1:0]   = fifo_empty;
        srst_pad[NUM_CH-1:0]    = soft_reset;
    end

    assign addr_ok   = ({1'b0, data_in} < NUM_CH_CMP);
    assign hdr_empty = empty_pad[data_in];
    assign sel_empty = empty_pad[addr_sel];
    assign sel_srst  = srst_pad[addr_sel];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DECODE_ADDR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDR: begin
                if (pkt_valid) begin
                    if (!addr_ok) begin
                        next_state = DROP;
                    end else if (hdr_empty) begin
                        next_state = LOAD_FIRST_DATA;
                    end else begin
                        next_state = WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    next_state = DECODE_ADDR;
                end else if (low_packet_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDR;
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) begin
                    next_state = LOAD_FIRST_DATA;
                end else if (wait_tc) begin
                    next_state = DROP;
                end
            end
            DROP: begin
                if (!pkt_valid) begin
                    next_state = DECODE_ADDR;
                end
            end
            default: next_state = DECODE_ADDR;
        endcase
        // A soft reset of the active channel aborts the packet from any busy state.
        if (sel_srst && (state != DECODE_ADDR) && (state != DROP)) begin
            next_state = DECODE_ADDR;
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b0;
        drop_pkt      = 1'b0;
        case (state)
            DECODE_ADDR:        detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            WAIT_TILL_EMPTY:    busy = 1'b1;
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            DROP:               drop_pkt = 1'b1;
            default:            detect_add = 1'b0;
        endcase
    end

    // Address is captured only on the cycle the header is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_sel <= '0;
            timeout  <= 1'b0;
        end else begin
            if ((state == DECODE_ADDR) && (next_state != DECODE_ADDR)) begin
                addr_sel <= data_in;
            end
            timeout <= (state == WAIT_TILL_EMPTY) && (next_state == DROP);
        end
    end

    // Loaded with WAIT_TIMEOUT-1 on entry so terminal count lands on the last allowed wait cycle.
    assign wait_load  = (state != WAIT_TILL_EMPTY) && (next_state == WAIT_TILL_EMPTY);
    assign wait_clear = (state == WAIT_TILL_EMPTY) && (next_state != WAIT_TILL_EMPTY);
    assign wait_dec   = (state == WAIT_TILL_EMPTY);

    router_wait_timer #(
        .WIDTH (CNT_W)
    ) u_wait_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (wait_clear),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .dec      (wait_dec),
        .tc       (wait_tc)
    );

endmodule
